// File: rtl/alu_instr_sequencer.sv
// Hardwired T-state control FSM for data_path: fetch (T0-T2) then one register-register ALU op (T3-T6).
// Latency: T0 one cycle after start is sampled; done in T5 (T6 for MUL/DIV); T1 stretches while mem_ready=0.
// Backpressure: mem_ready holds T1; with CTRL_SINGLE_STEP_EN defined every non-IDLE state also waits for step.
module alu_instr_sequencer #(
    parameter logic [4:0] OP_MUL = 5'b01110,
    parameter logic [4:0] OP_DIV = 5'b01111,
    parameter logic [4:0] OP_NEG = 5'b10000,
    parameter logic [4:0] OP_NOT = 5'b10001,
    parameter logic [4:0] OP_MAX = 5'b10001
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_ready,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [4:0]  op,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic        PCout,
    output logic        PCin,
    output logic        InPC,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        ZHighin,
    output logic        Zlowin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_ERR
    } state_t;

    state_t state, state_nxt;

    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic       is_unary, is_hilo, is_bad;
    logic       adv;
    logic       inpc_en;
    logic       ir_unused;

    assign opc       = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign ir_unused = ^ir[14:0];

    assign is_unary = (opc == OP_NEG) || (opc == OP_NOT);
    assign is_hilo  = (opc == OP_MUL) || (opc == OP_DIV);
    assign is_bad   = (opc > OP_MAX);

`ifdef CTRL_SINGLE_STEP_EN
    // Held T0 keeps reloading MAR/Z harmlessly, but the PC must only increment once.
    logic inpc_seen;

    always_ff @(posedge Clock) begin
        if (!clear) inpc_seen <= 1'b0;
        else        inpc_seen <= (state == S_T0);
    end

    assign adv     = step;
    assign inpc_en = ~inpc_seen;
`else
    assign adv     = 1'b1;
    assign inpc_en = 1'b1;
`endif

    always_ff @(posedge Clock) begin
        if (!clear) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start)            state_nxt = S_T0;
            S_T0:   if (adv)              state_nxt = S_T1;
            S_T1:   if (adv && mem_ready) state_nxt = S_T2;
            S_T2:   if (adv)              state_nxt = S_T3;
            S_T3:   if (adv)              state_nxt = is_bad ? S_ERR : S_T4;
            S_T4:   if (adv)              state_nxt = S_T5;
            S_T5:   if (adv)              state_nxt = is_hilo ? S_T6 : S_IDLE;
            S_T6:   if (adv)              state_nxt = S_IDLE;
            S_ERR:  if (adv)              state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        done     = 1'b0;
        illegal  = 1'b0;
        op       = 5'b0;
        Rout     = 16'h0000;
        Rin      = 16'h0000;
        PCout    = 1'b0;
        PCin     = 1'b0;
        InPC     = 1'b0;
        MARin    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        ZHighin  = 1'b0;
        Zlowin   = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        case (state)
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                InPC    = inpc_en;
                ZHighin = 1'b1;
                Zlowin  = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            // Unary ops feed the ALU straight from the bus in T4, so Y is left alone.
            S_T3: begin
                if (!is_bad && !is_unary) begin
                    Rout = 16'h0001 << rb;
                    Yin  = 1'b1;
                end
            end
            S_T4: begin
                op      = opc;
                ZHighin = 1'b1;
                Zlowin  = 1'b1;
                Rout    = 16'h0001 << (is_unary ? rb : rc);
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_hilo) begin
                    LOin = 1'b1;
                end else begin
                    Rin  = 16'h0001 << ra;
                    done = 1'b1;
                end
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            S_ERR: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule
